uart_rx_timing_ctrl: RTL

Sequencer and configurator for the UART receive datapath. It divides the system clock down to the oversampling tick rate and generates the per-bit o_strobe / o_half timing pulses consumed by the RX FSM. It validates the start bit at mid-bit and requests an RX restart on a glitch. It also keeps saturating receive-statistics counters for software. It sits between the RX FSM (whose prescaler-enable, error and FIFO-write outputs it consumes) and the CSR block.

---
 rtl/uart_rx_timing_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_timing_ctrl.sv
// ============================================================================
// Module      : uart_rx_timing_ctrl
// Description : UART RX oversample tick generator, bit strobe / mid-bit
//               pulse decoder, start-bit validator and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_timing_ctrl #(
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int STAT_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DIV_WIDTH-1:0]  i_div,
   input  logic                  i_prescaler_en,
   input  logic                  i_rx,
   input  logic                  i_parity_error,
   input  logic                  i_stop_bit_error,
   input  logic                  i_fifo_write_en,
   input  logic                  i_stat_clr,
   output logic                  o_strobe,
   output logic                  o_half,
   output logic                  o_rx_restart,
   output logic                  o_false_start,
   output logic [STAT_WIDTH-1:0] o_frame_cnt,
   output logic [STAT_WIDTH-1:0] o_parity_err_cnt,
   output logic [STAT_WIDTH-1:0] o_stop_err_cnt,
   output logic [STAT_WIDTH-1:0] o_false_start_cnt
);

   localparam int                c_OS_W    = $clog2(OVERSAMPLE);
   localparam logic [c_OS_W-1:0] c_OS_HALF = c_OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START_CHK = 2'd1,
      S_RUN       = 2'd2,
      S_HOLDOFF   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DIV_WIDTH-1:0]  r_div_q;
   logic [DIV_WIDTH-1:0]  r_div_cnt;
   logic [c_OS_W-1:0]     r_os_cnt;
   logic                  w_counting;
   logic                  w_tick;
   logic                  w_half;
   logic                  w_strobe;
   logic                  w_false_start;
   logic [3:0]            w_stat_evt;

   assign w_counting = ((r_state == S_START_CHK) || (r_state == S_RUN)) && i_prescaler_en;
   assign w_tick     = (r_div_cnt == r_div_q);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The divider setting is captured only on leaving IDLE so a frame keeps its rate.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_div_q   <= '0;
         r_div_cnt <= '0;
         r_os_cnt  <= '0;
      end else begin
         if ((r_state == S_IDLE) && i_prescaler_en) begin
            r_div_q <= i_div;
         end
         if (w_counting) begin
            if (w_tick) begin
               r_div_cnt <= '0;
               r_os_cnt  <= (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;
            end else begin
               r_div_cnt <= r_div_cnt + 1'b1;
            end
         end else begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_half        = 1'b0;
      w_strobe      = 1'b0;
      w_false_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_prescaler_en) w_state_nxt = S_START_CHK;
         end
         S_START_CHK: begin
            if (!i_prescaler_en) begin
               w_state_nxt = S_IDLE;
            end else if (w_tick && (r_os_cnt == c_OS_HALF)) begin
               if (i_rx) begin
                  w_false_start = 1'b1;
                  w_state_nxt   = S_HOLDOFF;
               end else begin
                  w_half      = 1'b1;
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (!i_prescaler_en) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_half   = w_tick && (r_os_cnt == c_OS_HALF);
               w_strobe = w_tick && (r_os_cnt == c_OS_LAST);
            end
         end
         S_HOLDOFF: begin
            if (!i_prescaler_en) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pulses are masked during reset so an aborted frame emits nothing.
   assign o_half        = w_half        & i_rst_n;
   assign o_strobe      = w_strobe      & i_rst_n;
   assign o_false_start = w_false_start & i_rst_n;
   assign o_rx_restart  = w_false_start & i_rst_n;

   assign w_stat_evt = {w_false_start, i_stop_bit_error, i_parity_error, i_fifo_write_en};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_stat
         logic [STAT_WIDTH-1:0] r_cnt;
         always_ff @(posedge i_clk) begin
            if (!i_rst_n || i_stat_clr) begin
               r_cnt <= '0;
            end else if (w_stat_evt[gi] && !(&r_cnt)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

   assign o_frame_cnt       = g_stat[0].r_cnt;
   assign o_parity_err_cnt  = g_stat[1].r_cnt;
   assign o_stop_err_cnt    = g_stat[2].r_cnt;
   assign o_false_start_cnt = g_stat[3].r_cnt;

endmodule

`default_nettype wire
